// File: rtl/bp_lce_req_arb.sv
// LCE request arbiter: one single-entry buffer and one credit counter per source, merged onto one network port.
// Define BP_LCE_REQ_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; otherwise round-robin.
module bp_lce_req_arb #(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 128,  // lce_req_msg_width_lp of the full coherence configuration
  parameter int credits_p   = 8     // coh_noc_max_credits_p
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_i,
  input  logic [num_req_p-1:0]             req_v_i,
  output logic [num_req_p-1:0]             ready_o,
  input  logic [num_req_p-1:0]             credit_return_i,
  output logic [num_req_p-1:0]             credits_full_o,
  output logic [num_req_p-1:0]             credits_empty_o,
  output logic [msg_width_p-1:0]           lce_req_o,
  output logic                             lce_req_v_o,
  input  logic                             lce_req_ready_i
);

  localparam int lg_req_lp = $clog2(num_req_p);
  localparam int cnt_w_lp  = $clog2(credits_p + 1);
  localparam logic [cnt_w_lp-1:0] credits_lp = cnt_w_lp'(credits_p);

  logic [num_req_p-1:0]   buf_v_q, buf_v_d;
  logic [msg_width_p-1:0] buf_msg_q [num_req_p];
  logic [msg_width_p-1:0] buf_msg_d [num_req_p];
  logic [cnt_w_lp-1:0]    cnt_q [num_req_p];
  logic [cnt_w_lp-1:0]    cnt_d [num_req_p];
  logic [lg_req_lp-1:0]   grant_idx;
  logic                   send;

  // Status comes only from registered state, so ready never waits on this cycle's valid or credit return.
  always_comb begin
    credits_full_o  = '0;
    credits_empty_o = '0;
    ready_o         = '0;
    for (int i = 0; i < num_req_p; i++) begin
      credits_full_o[i]  = (cnt_q[i] == credits_lp);
      credits_empty_o[i] = (cnt_q[i] == '0);
      ready_o[i]         = ~buf_v_q[i] & (cnt_q[i] != credits_lp);
    end
  end

`ifdef BP_LCE_REQ_ARB_FIXED_PRIO_EN
  always_comb begin
    logic found;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && buf_v_q[i]) begin
        found     = 1'b1;
        grant_idx = lg_req_lp'(i);
      end
    end
  end
`else
  logic [lg_req_lp-1:0] last_q, last_d;

  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= num_req_p; off++) begin
      idx = (int'(last_q) + off) % num_req_p;
      if (!found && buf_v_q[idx]) begin
        found     = 1'b1;
        grant_idx = lg_req_lp'(idx);
      end
    end
  end

  always_comb last_d = send ? grant_idx : last_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= lg_req_lp'(num_req_p - 1);
    else         last_q <= last_d;
  end
`endif

  assign send        = lce_req_ready_i & (|buf_v_q);
  assign lce_req_v_o = send;
  assign lce_req_o   = (|buf_v_q) ? buf_msg_q[grant_idx] : '0;

  // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    logic accept;
    buf_v_d = buf_v_q;
    for (int i = 0; i < num_req_p; i++) begin
      buf_msg_d[i] = buf_msg_q[i];
      cnt_d[i]     = cnt_q[i];
      accept       = req_v_i[i] & ready_o[i];
      if (accept) begin
        buf_v_d[i]   = 1'b1;
        buf_msg_d[i] = req_i[i*msg_width_p +: msg_width_p];
      end else if (send && (grant_idx == lg_req_lp'(i))) begin
        buf_v_d[i] = 1'b0;
      end
      if (accept && !credit_return_i[i])
        cnt_d[i] = cnt_q[i] + cnt_w_lp'(1);
      else if (!accept && credit_return_i[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - cnt_w_lp'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_v_q <= '0;
      for (int i = 0; i < num_req_p; i++) cnt_q[i] <= '0;
    end else begin
      buf_v_q <= buf_v_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the payload store is deliberately not reset; buf_v qualifies it and lce_req_o is zero when empty.
  always_ff @(posedge clk_i) begin
    buf_msg_q <= buf_msg_d;
  end

endmodule

// File: tb/tb_bp_lce_req_arb.sv
// Bench for bp_lce_req_arb (num_req_p=2, credits_p=2): directed scenarios plus random traffic against a queue-level model.
module tb_bp_lce_req_arb;

  localparam int N = 2;
  localparam int W = 16;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] req_i;
  logic [N-1:0]   req_v_i, ready_o, credit_return_i, credits_full_o, credits_empty_o;
  logic [W-1:0]   lce_req_o;
  logic           lce_req_v_o, lce_req_ready_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per-source "holding a message" flag, the held message, outstanding count, last source served.
  bit           mv [N];
  logic [W-1:0] mm [N];
  int           mc [N];
  int           mlast;

  always #5 clk = ~clk;

  bp_lce_req_arb #(.num_req_p(N), .msg_width_p(W), .credits_p(C)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .req_v_i(req_v_i), .ready_o(ready_o),
    .credit_return_i(credit_return_i), .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o), .lce_req_o(lce_req_o), .lce_req_v_o(lce_req_v_o),
    .lce_req_ready_i(lce_req_ready_i)
  );

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k] = !mv[k] && (mc[k] < C);
    return r;
  endfunction

  function automatic logic [N-1:0] m_full();
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k] = (mc[k] == C);
    return r;
  endfunction

  function automatic logic [N-1:0] m_empty();
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k] = (mc[k] == 0);
    return r;
  endfunction

  // Source that would be served now, or -1 if nothing is held.
  function automatic int m_grant();
    int g;
    g = -1;
`ifdef BP_LCE_REQ_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (g < 0 && mv[k]) g = k;
`else
    for (int k = 1; k <= N; k++) if (g < 0 && mv[(mlast + k) % N]) g = (mlast + k) % N;
`endif
    return g;
  endfunction

  function automatic logic [W-1:0] m_msg();
    int g;
    g = m_grant();
    return (g < 0) ? '0 : mm[g];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = 1'b0;
      mm[k] = '0;
      mc[k] = 0;
    end
    mlast = N - 1;
  endtask

  // Drive one cycle's inputs just after an edge; valids are only raised where the model says ready.
  task automatic apply(input logic [N-1:0] rv, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [N-1:0] ret, input logic nrdy);
    logic [N-1:0] r;
    r               = m_ready();
    req_v_i         = rv & r;
    req_i           = {d1, d0};
    credit_return_i = ret;
    lce_req_ready_i = nrdy;
    #1;
  endtask

  // Advance the model by the current inputs, then cross the next clock edge.
  task automatic commit();
    logic [N-1:0] r;
    logic         acc;
    int           g;
    r = m_ready();
    g = m_grant();
    if (lce_req_ready_i && g >= 0) begin
      mv[g] = 1'b0;
      mlast = g;
    end
    for (int k = 0; k < N; k++) begin
      acc = req_v_i[k] && r[k];
      if (acc) begin
        mv[k] = 1'b1;
        mm[k] = req_i[k*W +: W];
      end
      if (acc && !credit_return_i[k]) mc[k]++;
      else if (!acc && credit_return_i[k] && mc[k] > 0) mc[k]--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_i         = 1'b1;
    req_v_i         = '0;
    req_i           = '0;
    credit_return_i = '0;
    lce_req_ready_i = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(2);
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (ready_o !== 2'b11) begin n_bad++; $display("FAIL reset_ready: got %b want 11", ready_o); end
    n_cmp++; if (credits_empty_o !== 2'b11) begin n_bad++; $display("FAIL reset_empty: got %b want 11", credits_empty_o); end
    n_cmp++; if (credits_full_o !== 2'b00) begin n_bad++; $display("FAIL reset_full: got %b want 00", credits_full_o); end
    n_cmp++; if (lce_req_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_v: got %b want 0", lce_req_v_o); end
    n_cmp++; if (lce_req_o !== '0) begin n_bad++; $display("FAIL reset_msg: got %h want 0", lce_req_o); end
    commit();
  endtask

  task automatic test_simultaneous();
    do_reset(1);
    apply(2'b11, 16'hA0A0, 16'hB1B1, '0, 1'b1);
    n_cmp++; if (lce_req_v_o !== 1'b0) begin n_bad++; $display("FAIL sim_accept_v: got %b want 0", lce_req_v_o); end
    commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (ready_o !== 2'b00) begin n_bad++; $display("FAIL sim_held_ready: got %b want 00", ready_o); end
    n_cmp++; if (lce_req_v_o !== 1'b1 || lce_req_o !== 16'hA0A0) begin
      n_bad++; $display("FAIL sim_first: got v=%b msg=%h want v=1 msg=a0a0", lce_req_v_o, lce_req_o);
    end
    commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (lce_req_v_o !== 1'b1 || lce_req_o !== 16'hB1B1) begin
      n_bad++; $display("FAIL sim_second: got v=%b msg=%h want v=1 msg=b1b1", lce_req_v_o, lce_req_o);
    end
    commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (lce_req_v_o !== 1'b0 || lce_req_o !== '0) begin
      n_bad++; $display("FAIL sim_drained: got v=%b msg=%h want v=0 msg=0", lce_req_v_o, lce_req_o);
    end
    commit();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ret;
    do_reset(1);
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < N; k++) ret[k] = (mc[k] > 0);
      apply(2'b11, {4'h0, 12'(c)}, {4'h1, 12'(c)}, ret, 1'b1);
      if (c >= 1) begin
        n_cmp++; if (lce_req_v_o !== 1'b1 || lce_req_o[W-1:W-4] !== 4'((c - 1) % 2)) begin
          n_bad++; $display("FAIL b2b_grant cyc%0d: got v=%b src=%h want v=1 src=%0d",
                            c, lce_req_v_o, lce_req_o[W-1:W-4], (c - 1) % 2);
        end
        n_cmp++; if (lce_req_o !== m_msg()) begin
          n_bad++; $display("FAIL b2b_msg cyc%0d: got %h want %h", c, lce_req_o, m_msg());
        end
      end
      commit();
    end
  endtask

  task automatic test_credits_full();
    do_reset(1);
    apply(2'b01, 16'h0001, '0, '0, 1'b1); commit();
    apply('0, '0, '0, '0, 1'b1);           commit();
    apply(2'b01, 16'h0002, '0, '0, 1'b1); commit();
    apply('0, '0, '0, '0, 1'b1);           commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (credits_full_o[0] !== 1'b1 || ready_o[0] !== 1'b0) begin
      n_bad++; $display("FAIL cred_full: got full=%b ready=%b want full=1 ready=0", credits_full_o[0], ready_o[0]);
    end
    commit();
    apply('0, '0, '0, 2'b01, 1'b1);
    n_cmp++; if (ready_o[0] !== 1'b0) begin n_bad++; $display("FAIL cred_same_cycle_ready: got %b want 0", ready_o[0]); end
    commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (ready_o[0] !== 1'b1 || credits_full_o[0] !== 1'b0 || credits_empty_o[0] !== 1'b0) begin
      n_bad++; $display("FAIL cred_after_return: got ready=%b full=%b empty=%b want 1 0 0",
                        ready_o[0], credits_full_o[0], credits_empty_o[0]);
    end
    commit();
  endtask

  task automatic test_stall();
    logic [W-1:0] first, second;
`ifdef BP_LCE_REQ_ARB_FIXED_PRIO_EN
    first = 16'hCCCC; second = 16'hBBBB;
`else
    first = 16'hBBBB; second = 16'hCCCC;
`endif
    do_reset(1);
    apply(2'b01, 16'hAAAA, '0, '0, 1'b1); commit();
    apply(2'b10, '0, 16'hBBBB, '0, 1'b1);
    n_cmp++; if (lce_req_o !== 16'hAAAA) begin n_bad++; $display("FAIL stall_pre: got %h want aaaa", lce_req_o); end
    commit();
    apply(2'b01, 16'hCCCC, '0, '0, 1'b0); commit();
    for (int c = 0; c < 5; c++) begin
      apply('0, '0, '0, '0, 1'b0);
      n_cmp++; if (lce_req_v_o !== 1'b0 || ready_o !== 2'b00 || lce_req_o !== first) begin
        n_bad++; $display("FAIL stall_hold cyc%0d: got v=%b ready=%b msg=%h want v=0 ready=00 msg=%h",
                          c, lce_req_v_o, ready_o, lce_req_o, first);
      end
      commit();
    end
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (lce_req_v_o !== 1'b1 || lce_req_o !== first) begin
      n_bad++; $display("FAIL stall_drain1: got v=%b msg=%h want v=1 msg=%h", lce_req_v_o, lce_req_o, first);
    end
    commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (lce_req_v_o !== 1'b1 || lce_req_o !== second) begin
      n_bad++; $display("FAIL stall_drain2: got v=%b msg=%h want v=1 msg=%h", lce_req_v_o, lce_req_o, second);
    end
    commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (lce_req_v_o !== 1'b0) begin n_bad++; $display("FAIL stall_done: got v=%b want 0", lce_req_v_o); end
    commit();
  endtask

  task automatic test_credit_edges();
    do_reset(1);
    apply(2'b10, '0, 16'h1111, '0, 1'b1); commit();
    apply('0, '0, '0, '0, 1'b1);           commit();
    apply(2'b10, '0, 16'h2222, 2'b10, 1'b1); commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (credits_empty_o[1] !== 1'b0 || credits_full_o[1] !== 1'b0) begin
      n_bad++; $display("FAIL edge_both: got empty=%b full=%b want 0 0 (count 1)", credits_empty_o[1], credits_full_o[1]);
    end
    commit();
    apply('0, '0, '0, 2'b10, 1'b1); commit();
    apply('0, '0, '0, 2'b10, 1'b1);
    n_cmp++; if (credits_empty_o[1] !== 1'b1) begin n_bad++; $display("FAIL edge_to_zero: got empty=%b want 1", credits_empty_o[1]); end
    commit();
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (credits_empty_o[1] !== 1'b1 || credits_full_o[1] !== 1'b0 || ready_o[1] !== 1'b1) begin
      n_bad++; $display("FAIL edge_no_wrap: got empty=%b full=%b ready=%b want 1 0 1",
                        credits_empty_o[1], credits_full_o[1], ready_o[1]);
    end
    commit();
  endtask

  task automatic test_reset_inflight();
    do_reset(1);
    apply(2'b11, 16'h0101, 16'h1010, '0, 1'b1); commit();
    apply('0, '0, '0, '0, 1'b1);                commit();
    apply(2'b01, 16'h0202, '0, '0, 1'b1);       commit();
    apply(2'b10, '0, 16'h2020, '0, 1'b0);       commit();
    apply('0, '0, '0, '0, 1'b0);
    n_cmp++; if (credits_full_o !== 2'b11 || ready_o !== 2'b00) begin
      n_bad++; $display("FAIL inflight_setup: got full=%b ready=%b want 11 00", credits_full_o, ready_o);
    end
    do_reset(1);
    apply('0, '0, '0, '0, 1'b1);
    n_cmp++; if (ready_o !== 2'b11 || credits_empty_o !== 2'b11 || credits_full_o !== 2'b00) begin
      n_bad++; $display("FAIL inflight_status: got ready=%b empty=%b full=%b want 11 11 00",
                        ready_o, credits_empty_o, credits_full_o);
    end
    n_cmp++; if (lce_req_v_o !== 1'b0 || lce_req_o !== '0) begin
      n_bad++; $display("FAIL inflight_out: got v=%b msg=%h want 0 0", lce_req_v_o, lce_req_o);
    end
    commit();
  endtask

  task automatic test_random();
    logic [N-1:0] rv, ret;
    logic [W-1:0] d0, d1;
    logic         nrdy;
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      rv   = N'($urandom);
      d0   = W'($urandom);
      d1   = W'($urandom);
      nrdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) ret[k] = ($urandom_range(0, 2) == 0) && (mc[k] > 0);
      apply(rv, d0, d1, ret, nrdy);
      n_cmp++; if (ready_o !== m_ready()) begin
        n_bad++; $display("FAIL rnd_ready cyc%0d: got %b want %b", c, ready_o, m_ready());
      end
      n_cmp++; if (credits_full_o !== m_full() || credits_empty_o !== m_empty()) begin
        n_bad++; $display("FAIL rnd_credits cyc%0d: got full=%b empty=%b want %b %b",
                          c, credits_full_o, credits_empty_o, m_full(), m_empty());
      end
      n_cmp++; if (lce_req_v_o !== (nrdy && m_grant() >= 0)) begin
        n_bad++; $display("FAIL rnd_v cyc%0d: got %b want %b", c, lce_req_v_o, nrdy && m_grant() >= 0);
      end
      n_cmp++; if (lce_req_o !== m_msg()) begin
        n_bad++; $display("FAIL rnd_msg cyc%0d: got %h want %h", c, lce_req_o, m_msg());
      end
      commit();
    end
  endtask

  initial begin
    reset_i         = 1'b1;
    req_v_i         = '0;
    req_i           = '0;
    credit_return_i = '0;
    lce_req_ready_i = 1'b0;
    model_reset();
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_credits_full();
    test_stall();
    test_credit_edges();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/bp_lce_req_arb.md
BP_LCE_REQ_ARB -- requirements
Module: bp_lce_req_arb

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of LCE request sources, at least 2.
REQ-002 SHALL have parameter msg_width_p, default lce_req_msg_width_lp: width of one packed LCE request message.
REQ-003 SHALL have parameter credits_p, default coh_noc_max_credits_p: maximum outstanding requests allowed per source.
REQ-004 SHALL have the following ports:
- clk_i, input, 1: the single clock.
- reset_i, input, 1: synchronous, active-high reset.
- req_i, input, num_req_p*msg_width_p: per-source request message; source i occupies slice i.
- req_v_i, input, num_req_p: per-source valid, asserted only while ready_o[i] is high.
- ready_o, output, num_req_p: per-source ready.
- credit_return_i, input, num_req_p: per-source completion pulse returning one credit.
- credits_full_o, output, num_req_p: outstanding count for source i equals credits_p.
- credits_empty_o, output, num_req_p: outstanding count for source i equals 0.
- lce_req_o, output, msg_width_p: arbitrated message.
- lce_req_v_o, output, 1: arbitrated valid.
- lce_req_ready_i, input, 1: network ready.

Function
REQ-005 SHALL hold one single-entry message buffer per source, consisting of buf_v[i] and buf_msg[i].
REQ-006 SHALL drive ready_o[i] = ~buf_v[i] & ~credits_full_o[i]; ready_o[i] SHALL NOT depend on any req_v_i bit.
REQ-007 SHALL accept a message from source i on req_v_i[i] & ready_o[i]: buf_msg[i] captures req_i slice i and buf_v[i] sets on the next edge.
REQ-008 SHALL drive lce_req_v_o = lce_req_ready_i & (|buf_v), so that lce_req_v_o is never high while lce_req_ready_i is low.
REQ-009 SHALL select the granted source combinationally among the set buf_v bits, per REQ-018.
- lce_req_o SHALL equal buf_msg of the granted source.
- lce_req_o SHALL be all zeros when no buf_v bit is set.
REQ-010 SHALL clear buf_v of the granted source on the edge following a cycle in which lce_req_v_o is high; at most one message is sent per cycle.
REQ-011 SHALL have a minimum latency from acceptance to lce_req_v_o of 1 cycle. The buffer refills no earlier than the cycle after it drains, so each source sustains at most 1 message per 2 cycles.
REQ-012 SHALL keep a round-robin pointer last_r, width clog2(num_req_p).
- last_r SHALL update to the granted index only when lce_req_v_o is high.
- Search order SHALL be last_r+1, last_r+2, ..., wrapping modulo num_req_p.
REQ-013 SHALL keep a per-source credit counter of width `BSG_WIDTH(credits_p).
- Increment on acceptance (REQ-007).
- Decrement on credit_return_i[i].
- Both in the same cycle: counter unchanged.
REQ-014 SHALL ignore credit_return_i[i] when the counter is 0; the counter stays at 0 and does not wrap.
REQ-015 SHALL drive credits_full_o and credits_empty_o combinationally from the registered counters.
REQ-016 SHALL let a credit returned while the counter is full make ready_o[i] rise on the following cycle, not the same cycle.

Reset
REQ-017 SHALL, while reset_i is high at a clock edge, clear all of the following regardless of in-flight state; buffered messages are discarded:
- every buf_v bit and every credit counter, giving ready_o all ones, credits_empty_o all ones, credits_full_o all zeros, lce_req_v_o 0 and lce_req_o 0 after reset;
- last_r set to num_req_p-1, so source 0 has first priority.

Configuration
REQ-018 SHALL support macro BP_LCE_REQ_ARB_FIXED_PRIO_EN:
- When defined: grant goes to the lowest-index set buf_v bit, and last_r is neither implemented nor used.
- When undefined: round-robin grant per REQ-012.
- All ports and all other behaviour SHALL be identical in both builds.

Verification
Parameters for REQ-019 to REQ-023: num_req_p=2, credits_p=2, round-robin build unless stated.
REQ-019 SHALL cover: after reset, both sources offer one message in the same cycle, lce_req_ready_i=1 -> source 0 is sent on cycle +1 and source 1 on cycle +2.
REQ-020 SHALL cover: both sources offer back-to-back continuously, lce_req_ready_i=1 -> grants alternate 0,1,0,1; with FIXED_PRIO_EN defined -> source 0 is granted whenever its buffer is valid.
REQ-021 SHALL cover: source 0 sends 2 messages with no return -> credits_full_o[0]=1 and ready_o[0]=0; credit_return_i[0] pulse -> ready_o[0]=1 on the next cycle and the count equals 1.
REQ-022 SHALL cover: lce_req_ready_i=0 for 5 cycles with both buffers valid -> lce_req_v_o stays 0, buffers hold, last_r unchanged; ready returns -> normal drain.
REQ-023 SHALL cover: acceptance and credit_return_i[1] in the same cycle at count 1 -> count stays 1; credit_return_i[1] at count 0 -> count stays 0.
REQ-024 SHALL cover: reset_i asserted while both buffers are valid and counters equal 2 -> next cycle ready_o=2'b11, credits_empty_o=2'b11, lce_req_v_o=0.
